// File: rtl/prio_encoder_8to3.sv
// prio_encoder_8to3: registered 8-to-3 event encoder with pending register, capture mask and sticky overflow.
// Latency: a request sampled at edge N is visible on o_valid/o_code after that edge (1 cycle).
// Backpressure: o_valid/o_code hold until i_ready; one pending bit is retired per handshake, with no bubble.
// Build option: define PRIO_ENC_ROUND_ROBIN_EN for round-robin selection; otherwise the highest index wins.
module prio_encoder_8to3 #(
  parameter logic [7:0] MASK_RST = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  input  logic       i_mask_we,
  input  logic [7:0] i_mask_in,
  input  logic       i_ready,
  input  logic       i_ovf_clr,
  output logic       o_valid,
  output logic [2:0] o_code,
  output logic [7:0] o_pend,
  output logic       o_ovf
);

  logic [7:0] r_pend;
  logic [7:0] r_mask;
  logic       r_ovf;

  logic       w_valid;
  logic [2:0] w_code;
  logic       w_acc;
  logic [7:0] w_acc_onehot;
  logic [7:0] w_capture;
  logic       w_ovf_set;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [2:0] r_ptr;

  // Round-robin pick: first pending bit found searching from ptr upward, wrapping mod 8.
  // The loop walks the offsets downward so the smallest offset is the last (winning) assignment.
  always_comb begin
    logic [2:0] idx;
    w_code = 3'd0;
    idx    = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = r_ptr + 3'(k);
      if (r_pend[idx]) begin
        w_code = idx;
      end
    end
  end

  // Pointer moves to one past the accepted index (7 wraps to 0); otherwise it holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= 3'd0;
    end else if (w_acc) begin
      r_ptr <= w_code + 3'd1;
    end
  end
`else
  // Fixed priority: the highest set index in pend wins (later loop iterations override).
  always_comb begin
    w_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_pend[i]) begin
        w_code = 3'(i);
      end
    end
  end
`endif

  // Handshake, accept one-hot, masked capture and overflow detection, all from registered state.
  always_comb begin
    w_valid      = |r_pend;
    w_acc        = w_valid & i_ready;
    w_acc_onehot = w_acc ? (8'b0000_0001 << w_code) : 8'h00;
    w_capture    = i_req & r_mask;
    // A re-request of the bit being retired this cycle is a fresh capture, not an overflow.
    w_ovf_set    = |(w_capture & r_pend & ~w_acc_onehot);
  end

  // State update: reset dominates; capture beats the accept clear; an ovf set beats ovf_clr.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend <= 8'h00;
      r_mask <= MASK_RST;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_acc_onehot) | w_capture;
      if (i_mask_we) begin
        r_mask <= i_mask_in;
      end
      r_ovf <= w_ovf_set | (r_ovf & ~i_ovf_clr);
    end
  end

  assign o_valid = w_valid;
  assign o_code  = w_valid ? w_code : 3'd0;
  assign o_pend  = r_pend;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_prio_encoder_8to3.sv
// Bench for prio_encoder_8to3: directed vector table plus hand-written reset sequences.
// Each table row drives inputs for one clock edge and then checks the outputs that follow it.
// Expected code/pend values carry separate columns for the fixed and round-robin builds.
module tb_prio_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       ready;
  logic       ovf_clr;
  logic       valid;
  logic [2:0] code;
  logic [7:0] pend;
  logic       ovf;

  int checks;
  int errors;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [7:0] req;
    logic       mwe;
    logic [7:0] min;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [2:0] e_code_fix;
    logic [2:0] e_code_rr;
    logic [7:0] e_pend_fix;
    logic [7:0] e_pend_rr;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[34];

  prio_encoder_8to3 #(.MASK_RST(8'hFF)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_mask_we (mask_we),
    .i_mask_in (mask_in),
    .i_ready   (ready),
    .i_ovf_clr (ovf_clr),
    .o_valid   (valid),
    .o_code    (code),
    .o_pend    (pend),
    .o_ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic [2:0] e_code,
                           input logic [7:0] e_pend, input logic e_ovf);
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
    chk({tag, ".code"},  {5'd0, code},  {5'd0, e_code});
    chk({tag, ".pend"},  pend,          e_pend);
    chk({tag, ".ovf"},   {7'd0, ovf},   {7'd0, e_ovf});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = 8'hFF;
    mask_we = 1'b0;
    mask_in = 8'h00;
    ready   = 1'b1;
    ovf_clr = 1'b0;

    //            req    mwe  min    rdy  clr  val  cfix cRR  pfix   pRR    ovf
    // drain all eight requests (order differs per build)
    vecs[0]  = '{8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 3'd0, 8'hFF, 8'hFF, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 3'd1, 8'h7F, 8'hFE, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 3'd2, 8'h3F, 8'hFC, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 3'd3, 8'h1F, 8'hF8, 1'b0};
    vecs[4]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 3'd4, 8'h0F, 8'hF0, 1'b0};
    vecs[5]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 3'd5, 8'h07, 8'hE0, 1'b0};
    vecs[6]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 3'd6, 8'h03, 8'hC0, 1'b0};
    vecs[7]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 3'd7, 8'h01, 8'h80, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    // two requests, then two accepts
    vecs[9]  = '{8'h24, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 8'h24, 8'h24, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 3'd5, 8'h04, 8'h20, 1'b0};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    // overflow set, clear, and clear coincident with set
    vecs[12] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08, 1'b0};
    vecs[13] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08, 1'b1};
    vecs[14] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08, 1'b1};
    vecs[15] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08, 1'b0};
    vecs[16] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08, 1'b1};
    vecs[17] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    // re-request of the bit being accepted: stays pending, no overflow
    vecs[18] = '{8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 3'd6, 8'h40, 8'h40, 1'b0};
    vecs[19] = '{8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 3'd6, 8'h40, 8'h40, 1'b0};
    vecs[20] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    // mask load, masked-off requests ignored, unmasked request captured
    vecs[21] = '{8'h00, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[22] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[23] = '{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'h01, 8'h01, 1'b0};
    vecs[24] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    // pending bit stays selectable after its mask bit drops; masked re-request is not captured
    vecs[25] = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[26] = '{8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 8'h80, 8'h80, 1'b0};
    vecs[27] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 8'h80, 8'h80, 1'b0};
    vecs[28] = '{8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[29] = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    // pend=81 served under each policy; last row shows the pointer is back at 0
    vecs[30] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 3'd0, 8'h81, 8'h81, 1'b0};
    vecs[31] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 3'd7, 8'h01, 8'h80, 1'b0};
    vecs[32] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[33] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 3'd0, 8'h81, 8'h81, 1'b0};

    // Reset held two edges with every request asserted and ready high.
    tick();
    check_all("rst_edge1", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    check_all("rst_edge2", 1'b0, 3'd0, 8'h00, 1'b0);
    // Request seen in the same edge as release must not be captured early.
    req = 8'h00;
    ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check_all("post_rst", 1'b0, 3'd0, 8'h00, 1'b0);

    // Table: row 0 also shows the reset mask captures all eight lines.
    for (int i = 0; i < 34; i++) begin
      req     = vecs[i].req;
      mask_we = vecs[i].mwe;
      mask_in = vecs[i].min;
      ready   = vecs[i].rdy;
      ovf_clr = vecs[i].clr;
      tick();
      check_all($sformatf("row%0d", i), vecs[i].e_valid,
                RR ? vecs[i].e_code_rr : vecs[i].e_code_fix,
                RR ? vecs[i].e_pend_rr : vecs[i].e_pend_fix,
                vecs[i].e_ovf);
    end

    // Build up an overflow with pend=81, then reset during an accept: reset wins.
    req = 8'h81;
    ready = 1'b0;
    mask_we = 1'b0;
    ovf_clr = 1'b0;
    tick();
    check_all("ovf_before_rst", 1'b1, RR ? 3'd0 : 3'd7, 8'h81, 1'b1);
    rst_n = 1'b0;
    ready = 1'b1;
    tick();
    check_all("rst_during_acc", 1'b0, 3'd0, 8'h00, 1'b0);

    // After this reset the pointer is 0 again and the mask is back to all-ones.
    rst_n = 1'b1;
    req = 8'h12;
    ready = 1'b0;
    tick();
    check_all("after_rst2", 1'b1, RR ? 3'd1 : 3'd4, 8'h12, 1'b0);
    req = 8'h00;
    ready = 1'b1;
    tick();
    check_all("after_rst2_acc", 1'b1, RR ? 3'd4 : 3'd1, RR ? 8'h10 : 8'h02, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
